// File: rtl/bin2bcd_param.sv
// bin2bcd_param: sequential binary-to-BCD converter (shift-add-3), one input
// bit per clock. Widths are parametrised, with an optional signed mode that
// converts the magnitude and reports the sign separately.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      conversion request, honoured only while ready=1
//   bin        binary operand, captured on the accepted start cycle
//   ready      high while idle
//   done_tick  one-cycle pulse; bcd/blank/neg/overflow valid from here on
//   bcd        DIGITS packed BCD digits, digit 0 in bits [3:0]
//   blank      bit i set when digit i is a leading zero (bit 0 always 0)
//   neg        operand was negative (SIGNED=1 only)
//   overflow   magnitude exceeded 10^DIGITS-1; bcd holds the low digits
//
// State table:
//   IDLE | waiting for start, ready=1
//   OP   | shifting one bit per cycle, BIN_W cycles
//   DONE | results just loaded, done_tick=1
module bin2bcd_param #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  neg,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  // All digits above digit 0 blanked, digit 0 always shown.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t                  state;
  logic [BIN_W-1:0]        shift_reg;
  logic [BIN_W-1:0]        mag;
  logic [DIGITS-1:0][3:0]  work;
  logic [DIGITS-1:0][3:0]  corr;
  logic [DIGITS-1:0][3:0]  work_next;
  logic                    ovf_work;
  logic                    ovf_next;
  logic                    neg_pend;
  logic                    is_neg;
  logic [CNT_W-1:0]        count;
  logic [DIGITS-1:0]       blank_next;
  logic                    zero_above;

  assign ready = (state == IDLE);

  // Two's complement negate taken as unsigned, so the most negative value
  // maps onto its true magnitude 2^(BIN_W-1).
  assign is_neg = (SIGNED != 0) && bin[BIN_W-1];
  assign mag    = is_neg ? (~bin + BIN_W'(1)) : bin;

  // One double-dabble step: correct every digit, then shift the whole chain.
  // The carry out of the top digit is exactly the bit that no longer fits.
  always_comb begin
    corr      = '0;
    work_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      corr[i] = (work[i] > 4'd4) ? (work[i] + 4'd3) : work[i];
    end
    work_next[0] = {corr[0][2:0], shift_reg[BIN_W-1]};
    for (int i = 1; i < DIGITS; i++) begin
      work_next[i] = {corr[i][2:0], corr[i-1][3]};
    end
    ovf_next = ovf_work | corr[DIGITS-1][3];
  end

  // Leading-zero mask for the result about to be loaded.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (work_next[i] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      work      <= '0;
      ovf_work  <= 1'b0;
      neg_pend  <= 1'b0;
      count     <= '0;
      bcd       <= '0;
      blank     <= BLANK_RST;
      neg       <= 1'b0;
      overflow  <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= mag;
            work      <= '0;
            ovf_work  <= 1'b0;
            neg_pend  <= is_neg;
            count     <= CNT_W'(BIN_W);
            state     <= OP;
          end
        end
        OP: begin
          shift_reg <= shift_reg << 1;
          work      <= work_next;
          ovf_work  <= ovf_next;
          count     <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            // Final step: publish the post-shift values directly.
            state     <= DONE;
            done_tick <= 1'b1;
            bcd       <= work_next;
            blank     <= blank_next;
            neg       <= neg_pend;
            overflow  <= ovf_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_param.sv
// tb_bin2bcd_param: self-checking bench for bin2bcd_param. Instance u0 uses
// the default parameters, u1 is signed with BIN_W=8, DIGITS=3. Fixed vectors
// come from a table; random operands are checked against an arithmetic model.
module tb_bin2bcd_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [13:0] bin0;
  logic [7:0]  bin1;
  logic        ready0, done0, neg0, ovf0;
  logic [15:0] bcd0;
  logic [3:0]  blank0;
  logic        ready1, done1, neg1, ovf1;
  logic [11:0] bcd1;
  logic [2:0]  blank1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin2bcd_param u0 (
    .clk(clk), .reset(reset), .start(start0), .bin(bin0),
    .ready(ready0), .done_tick(done0), .bcd(bcd0), .blank(blank0),
    .neg(neg0), .overflow(ovf0)
  );

  bin2bcd_param #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin1),
    .ready(ready1), .done_tick(done1), .bcd(bcd1), .blank(blank1),
    .neg(neg1), .overflow(ovf1)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } vec0_t;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        neg;
  } vec1_t;

  vec0_t tbl0[7];
  vec1_t tbl1[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: value mod 10^nd split into digits, leading-zero mask
  // from integer division, overflow from a plain magnitude compare.
  function automatic void model(input longint mag, input int nd,
                                output logic [39:0] d, output logic [9:0] bl,
                                output logic ov);
    longint p = 1;
    longint m, t, pw;
    for (int i = 0; i < nd; i++) p = p * 10;
    ov = (mag >= p);
    m  = mag % p;
    d  = '0;
    bl = '0;
    t  = m;
    for (int i = 0; i < nd; i++) begin
      d[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    pw = 10;
    for (int i = 1; i < nd; i++) begin
      bl[i] = ((m / pw) == 0);
      pw = pw * 10;
    end
  endfunction

  task automatic run0(input logic [13:0] b, input logic [15:0] eb,
                      input logic [3:0] ebl, input logic eo, input string nm);
    int lat;
    @(negedge clk);
    start0 = 1'b1;
    bin0   = b;
    @(negedge clk);
    start0 = 1'b0;
    bin0   = 14'($urandom);
    chk({nm, " ready_low"}, 64'(ready0), 64'd0);
    lat = 1;
    while (!done0 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd15);
    chk({nm, " bcd"}, 64'(bcd0), 64'(eb));
    chk({nm, " blank"}, 64'(blank0), 64'(ebl));
    chk({nm, " overflow"}, 64'(ovf0), 64'(eo));
  endtask

  task automatic run1(input logic [7:0] b, input logic [11:0] eb,
                      input logic [2:0] ebl, input logic en, input string nm);
    int lat;
    @(negedge clk);
    start1 = 1'b1;
    bin1   = b;
    @(negedge clk);
    start1 = 1'b0;
    bin1   = 8'($urandom);
    lat = 1;
    while (!done1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " s_latency"}, 64'(lat), 64'd9);
    chk({nm, " s_bcd"}, 64'(bcd1), 64'(eb));
    chk({nm, " s_blank"}, 64'(blank1), 64'(ebl));
    chk({nm, " s_neg"}, 64'(neg1), 64'(en));
    chk({nm, " s_overflow"}, 64'(ovf1), 64'd0);
  endtask

  initial begin
    logic [39:0] ed;
    logic [9:0]  ebl;
    logic        eo;
    logic [13:0] rb0;
    logic [7:0]  rb1;
    longint      m1;
    int          dcount;
    logic        hold_bad;
    logic [15:0] got;

    tbl0[0] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
    tbl0[1] = '{14'd0,     16'h0000, 4'b1110, 1'b0};
    tbl0[2] = '{14'd407,   16'h0407, 4'b1000, 1'b0};
    tbl0[3] = '{14'd12345, 16'h2345, 4'b0000, 1'b1};
    tbl0[4] = '{14'd5,     16'h0005, 4'b1110, 1'b0};
    tbl0[5] = '{14'd10000, 16'h0000, 4'b1110, 1'b1};
    tbl0[6] = '{14'd16383, 16'h6383, 4'b0000, 1'b1};

    tbl1[0] = '{8'h80, 12'h128, 3'b000, 1'b1};
    tbl1[1] = '{8'hFF, 12'h001, 3'b110, 1'b1};
    tbl1[2] = '{8'h7F, 12'h127, 3'b000, 1'b0};
    tbl1[3] = '{8'h00, 12'h000, 3'b110, 1'b0};
    tbl1[4] = '{8'h81, 12'h127, 3'b000, 1'b1};
    tbl1[5] = '{8'h09, 12'h009, 3'b110, 1'b0};

    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    bin0   = '0;
    bin1   = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 64'(ready0), 64'd1);
    chk("rst bcd", 64'(bcd0), 64'd0);
    chk("rst blank", 64'(blank0), 64'(4'b1110));
    chk("rst overflow", 64'(ovf0), 64'd0);
    chk("rst done", 64'(done0), 64'd0);
    chk("rst s_blank", 64'(blank1), 64'(3'b110));
    chk("rst s_neg", 64'(neg1), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run0(tbl0[i].bin, tbl0[i].bcd, tbl0[i].blank, tbl0[i].ovf, $sformatf("tbl0[%0d]", i));

    // Hold and ignore: result stays 9999 through OP, starts in OP/DONE ignored.
    run0(14'd9999, 16'h9999, 4'b0000, 1'b0, "pre_hold");
    @(negedge clk);
    start0 = 1'b1;
    bin0   = 14'd1234;
    @(negedge clk);
    start0   = 1'b0;
    bin0     = 14'd5678;
    dcount   = 0;
    hold_bad = 1'b0;
    got      = '0;
    for (int c = 1; c <= 40; c++) begin
      if (done0) begin
        dcount++;
        got = bcd0;
      end else if (dcount == 0 && bcd0 !== 16'h9999) begin
        hold_bad = 1'b1;
      end
      start0 = (c == 5) || done0;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("hold single_done", 64'(dcount), 64'd1);
    chk("hold stable_in_op", 64'(hold_bad), 64'd0);
    chk("hold bcd_at_done", 64'(got), 64'h1234);
    chk("hold bcd_after", 64'(bcd0), 64'h1234);

    // Reset during OP, with start raised on the same edge.
    @(negedge clk);
    start0 = 1'b1;
    bin0   = 14'd1234;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    reset  = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start0 = 1'b0;
    chk("midrst ready", 64'(ready0), 64'd1);
    chk("midrst bcd", 64'(bcd0), 64'd0);
    chk("midrst blank", 64'(blank0), 64'(4'b1110));
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (done0) dcount++;
      @(negedge clk);
    end
    chk("midrst no_done", 64'(dcount), 64'd0);
    run0(14'd42, 16'h0042, 4'b1100, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rb0 = 14'($urandom);
      if (i % 3 == 0) rb0 = 14'($urandom_range(0, 120));
      model(longint'(rb0), 4, ed, ebl, eo);
      run0(rb0, ed[15:0], ebl[3:0], eo, $sformatf("rnd0 %0d", rb0));
    end

    for (int i = 0; i < 6; i++)
      run1(tbl1[i].bin, tbl1[i].bcd, tbl1[i].blank, tbl1[i].neg, $sformatf("tbl1[%0d]", i));

    for (int i = 0; i < 30; i++) begin
      rb1 = 8'($urandom);
      m1  = rb1[7] ? (256 - longint'(rb1)) : longint'(rb1);
      model(m1, 3, ed, ebl, eo);
      run1(rb1, ed[11:0], ebl[2:0], rb1[7], $sformatf("rnd1 %0h", rb1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_param.md
Name: bin2bcd_param

Overview:
Parametrised sequential binary-to-BCD converter using shift-add-3 (double-dabble), one bit per clock. It is the general successor to the fixed 14-bit/4-digit converter and feeds 7-segment display multiplexers and timer/score displays. It adds configurable width and digit count, a signed mode, overflow detection, leading-zero blanking, and outputs that are held stable during conversion.

Parameters:
BIN_W, 14, binary input width in bits (2..32)
DIGITS, 4, number of BCD digits produced (1..10)
SIGNED, 0, 1 = treat bin as two's complement and convert its magnitude

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only while ready=1
bin  input  BIN_W  binary operand; sampled on the start cycle only
ready  output  1  high in IDLE (combinational from state)
done_tick  output  1  one-cycle pulse; results valid from this cycle on
bcd  output  4*DIGITS  digit i at bits [4i+3:4i], digit 0 = least significant
blank  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0
neg  output  1  input was negative (SIGNED=1 only, else tied 0)
overflow  output  1  magnitude > 10^DIGITS-1; bcd then holds the low DIGITS digits

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state=IDLE; bcd=0; blank={DIGITS-1 ones, 0}; neg=0; overflow=0; done_tick=0. Internal shift, work and counter registers are cleared.
- State machine: IDLE -> OP -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On start=1: load the magnitude into the shift register, clear the work digits and sticky overflow, set counter=BIN_W, go to OP.
  - When SIGNED=1 and bin[BIN_W-1]=1, magnitude = (~bin)+1, taken as BIN_W-bit unsigned. -2^(BIN_W-1) therefore converts correctly.
  - Capture neg into a pending register.
- OP (exactly BIN_W cycles):
  - Each work digit >4 gets +3 (4-bit result).
  - Shift {digits, shift_reg} left by 1, MSB of shift_reg entering digit 0.
  - The bit shifted out of the top digit's corrected MSB ORs into sticky overflow.
  - Decrement the counter; leave for DONE when the counter reaches 1 in this cycle.
- DONE (1 cycle):
  - done_tick=1.
  - Output registers bcd, neg, overflow and blank load from the work/pending registers on the clock edge entering DONE. They are therefore valid while done_tick=1.
  - Next state is IDLE.
- Output hold: output registers change only on entry to DONE or on reset. They hold their previous result through OP and IDLE.
- Latency: start accepted at edge N → done_tick high during the cycle after edge N+BIN_W (BIN_W+1 cycles). Next start is accepted no earlier than edge N+BIN_W+2.
- ready=0 in OP and DONE; start there is ignored with no effect. bin changes after the start cycle have no effect.
- blank: bit i=1 iff digits i..DIGITS-1 are all zero (i≥1). Zero input → only digit 0 shown.
- Overflow: sticky within a conversion; cleared only by the next accepted start or reset. With overflow set, bcd = magnitude mod 10^DIGITS.
- Reset mid-operation: returns to IDLE next cycle with outputs at reset values; no done_tick is issued.
- Simultaneous start and reset: reset wins.
- Width: all digit arithmetic is 4-bit; the counter is clog2(BIN_W+1) bits.

Test Plan:
- Defaults, bin=9999, start one cycle → ready falls; done_tick exactly 15 cycles after the start edge; bcd=0x9999, overflow=0, blank=0000.
- Defaults, bin=0 → bcd=0x0000, blank=1110, overflow=0. Then bin=407 → bcd=0x0407, blank=1000.
- Defaults, bin=12345 → overflow=1, bcd=0x2345. A following conversion of bin=5 → overflow=0, bcd=0x0005, blank=1110.
- SIGNED=1, BIN_W=8, DIGITS=3:
  - bin=8'h80 → neg=1, bcd=0x128.
  - bin=8'hFF → neg=1, bcd=0x001.
  - bin=8'h7F → neg=0, bcd=0x127.
- Hold and ignore: while converting 1234, pulse start with bin=5678 mid-OP and in DONE. Required: single done_tick, bcd=0x1234. Output stays at the previous value (e.g. 0x9999) throughout OP.
- Reset mid-OP (cycle 6 of 14) → next cycle ready=1, bcd=0, blank=1110, no done_tick. A subsequent conversion of 42 → bcd=0x0042 with normal latency.
